// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI-Lite posted-write buffer.
package axil_pkg;
    localparam logic [1:0] RESP_OK            = 2'b00;
    localparam logic [1:0] SUBORDINATE_ERROR  = 2'b10;
    localparam logic [1:0] DECODE_ERROR       = 2'b11;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SEND,
        D_AWAIT_B
    } drain_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_RESP
    } read_state_t;
endpackage

// File: rtl/axi_if.sv
// AXI-Lite bundle. Handshake rule on every channel: a transfer happens on a rising
// edge where VALID and READY are both high; VALID never waits on READY.
interface axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport manager (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport subord (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_wb_fifo.sv
// Write-entry FIFO with extended pointers and a combinational youngest-match
// lookup over every live entry, the head included, for read forwarding.
module axil_wb_fifo #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int PTR_W     = $clog2(DEPTH) + 1,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [STRB_W-1:0]     push_strb,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [STRB_W-1:0]     head_strb,
    output logic [PTR_W-1:0]      count,
    input  logic [ADDR_WIDTH-3:0] lookup_word,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [STRB_W-1:0]     strb_mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [IDX_W-1:0]      idx;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail[IDX_W-1:0]] <= push_addr;
            data_mem[tail[IDX_W-1:0]] <= push_data;
            strb_mem[tail[IDX_W-1:0]] <= push_strb;
        end
    end

    // Entry liveness comes from the pointers, so resetting them invalidates everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    assign count     = tail - head;
    assign head_addr = addr_mem[head[IDX_W-1:0]];
    assign head_data = data_mem[head[IDX_W-1:0]];
    assign head_strb = strb_mem[head[IDX_W-1:0]];

    // Walk oldest to youngest; a later match overrides, leaving the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < count) && (addr_mem[idx][ADDR_WIDTH-1:2] == lookup_word)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end
endmodule

// File: rtl/axil_write_buffer.sv
// Posted-write buffer: acks cache writebacks at once, drains them in order one at a
// time, and serves reads from memory or, on a word hit, from the youngest buffered write.
module axil_write_buffer
    import axil_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi_if.subord                    up,
    axi_if.manager                   down,
    output drain_state_t             drain_state,
    output read_state_t              read_state,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    drain_state_t          drain_state_n;
    read_state_t           read_state_n;
    logic                  aw_done, aw_done_n, w_done, w_done_n;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_n;
    logic [DATA_WIDTH-1:0] rdata, rdata_n;
    logic                  bvalid, wr_ready, wr_accept, pop, sending, hit;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data, hit_data;
    logic [STRB_W-1:0]     head_strb;
    logic                  unused_bits;

    axil_wb_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk(ACLK), .rst(ARESET),
        .push(wr_accept), .push_addr(up.AWADDR), .push_data(up.WDATA), .push_strb(up.WSTRB),
        .pop(pop), .head_addr(head_addr), .head_data(head_data), .head_strb(head_strb),
        .count(count), .lookup_word(up.ARADDR[ADDR_WIDTH-1:2]), .hit(hit), .hit_data(hit_data)
    );

    // Readiness uses the registered count only: a same-cycle pop grants no credit.
    assign wr_ready   = !ARESET && (count < PTR_W'(DEPTH)) && !bvalid;
    assign wr_accept  = up.AWVALID && up.WVALID && wr_ready;
    assign up.AWREADY = wr_ready;
    assign up.WREADY  = wr_ready;
    assign up.BVALID  = bvalid;
    assign up.BRESP   = RESP_OK;
    assign up.ARREADY = !ARESET && (read_state == R_IDLE);
    assign up.RVALID  = (read_state == R_RESP);
    assign up.RDATA   = rdata;
    assign up.RRESP   = RESP_OK;

    assign sending      = (drain_state == D_SEND);
    assign down.AWVALID = sending && !aw_done;
    assign down.WVALID  = sending && !w_done;
    assign down.AWADDR  = sending ? head_addr : '0;
    assign down.WDATA   = sending ? head_data : '0;
    assign down.WSTRB   = sending ? head_strb : '0;
    assign down.AWPROT  = 3'b000;
    assign down.BREADY  = (drain_state == D_AWAIT_B);
    assign down.ARVALID = (read_state == R_ADDR);
    assign down.ARADDR  = (read_state == R_ADDR) ? rd_addr : '0;
    assign down.ARPROT  = 3'b000;
    assign down.RREADY  = (read_state == R_DATA);

    assign unused_bits = ^{up.AWPROT, up.ARPROT, down.BRESP, down.RRESP};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            drain_state <= D_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            read_state  <= R_IDLE;
            rd_addr     <= '0;
            rdata       <= '0;
            bvalid      <= 1'b0;
        end else begin
            drain_state <= drain_state_n;
            aw_done     <= aw_done_n;
            w_done      <= w_done_n;
            read_state  <= read_state_n;
            rd_addr     <= rd_addr_n;
            rdata       <= rdata_n;
            if (wr_accept)      bvalid <= 1'b1;
            else if (up.BREADY) bvalid <= 1'b0;
        end
    end

    // AW and W complete independently; each done flag retires its VALID.
    always_comb begin
        drain_state_n = drain_state;
        aw_done_n     = aw_done;
        w_done_n      = w_done;
        pop           = 1'b0;
        case (drain_state)
            D_IDLE:    if (count != '0) drain_state_n = D_SEND;
            D_SEND: begin
                aw_done_n = aw_done || down.AWREADY;
                w_done_n  = w_done || down.WREADY;
                if (aw_done_n && w_done_n) drain_state_n = D_AWAIT_B;
            end
            D_AWAIT_B: if (down.BVALID) begin
                pop           = 1'b1;
                aw_done_n     = 1'b0;
                w_done_n      = 1'b0;
                drain_state_n = D_IDLE;
            end
            default:   drain_state_n = D_IDLE;
        endcase
    end

    always_comb begin
        read_state_n = read_state;
        rd_addr_n    = rd_addr;
        rdata_n      = rdata;
        case (read_state)
            R_IDLE: if (up.ARVALID && up.ARREADY) begin
                if (hit) begin
                    rdata_n      = hit_data;
                    read_state_n = R_RESP;
                end else begin
                    rd_addr_n    = up.ARADDR;
                    read_state_n = R_ADDR;
                end
            end
            R_ADDR: if (down.ARREADY) read_state_n = R_DATA;
            R_DATA: if (down.RVALID) begin
                rdata_n      = down.RDATA;
                read_state_n = R_RESP;
            end
            R_RESP: if (up.RREADY) read_state_n = R_IDLE;
            default: read_state_n = R_IDLE;
        endcase
    end

    a_aw_w_paired: assert property (@(posedge ACLK) disable iff (ARESET) up.AWVALID == up.WVALID);
    a_full_strb:   assert property (@(posedge ACLK) disable iff (ARESET) wr_accept |-> (&up.WSTRB));
    a_single_port: assert property (@(posedge ACLK) disable iff (ARESET)
                                    up.ARVALID |-> (!up.AWVALID && !up.WVALID));
endmodule

// File: tb/tb_axil_write_buffer.sv
// Bench for axil_write_buffer: directed scenarios plus randomized traffic against a
// reference of in-order posted writes, latest-value reads and a responding memory.
module tb_axil_write_buffer;
    import axil_pkg::*;

    logic clk;
    logic rst;
    drain_state_t drain_state;
    read_state_t  read_state;
    logic [2:0]   count;

    axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();
    axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) down_if ();

    axil_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESET(rst), .up(up_if), .down(down_if),
        .drain_state(drain_state), .read_state(read_state), .count(count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];                // {addr, data} accepted upstream, not yet acked by memory
    logic [31:0] shadow [logic [29:0]];   // latest value written per word
    logic [31:0] mem    [logic [29:0]];   // memory contents as written downstream
    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs_count = 0;
    int ar_hs_count = 0;
    logic [31:0] last_ar_addr = '0;
    bit mem_aw_stall = 0;
    bit mem_random   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0], 16'h5A5A} ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return mem_default(a);
    endfunction

    function automatic bit buffered(input logic [31:0] a);
        foreach (exp_q[i]) if (exp_q[i][63:34] == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- downstream memory responder ----------------
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    logic [31:0] r_addr;
    logic [63:0] popped;
    bit have_aw, have_w, b_wait, b_hs, r_wait, r_hs;

    initial begin
        down_if.AWREADY = 0; down_if.WREADY = 0; down_if.BVALID = 0; down_if.BRESP = 2'b00;
        down_if.ARREADY = 0; down_if.RVALID = 0; down_if.RDATA = '0; down_if.RRESP = 2'b00;
        {have_aw, have_w, b_wait, b_hs, r_wait, r_hs} = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                down_if.AWREADY = 0; down_if.WREADY = 0; down_if.BVALID = 0;
                down_if.ARREADY = 0; down_if.RVALID = 0;
                {have_aw, have_w, b_wait, b_hs, r_wait, r_hs} = '0;
            end else begin
                if (b_hs) begin
                    if (exp_q.size() > 0) popped = exp_q.pop_front();
                    b_hs = 0; b_wait = 0; down_if.BVALID = 0;
                end
                if (r_hs) begin
                    r_hs = 0; r_wait = 0; down_if.RVALID = 0;
                end
                down_if.AWREADY = mem_aw_stall ? 1'b0 : (mem_random ? 1'($urandom_range(0, 1)) : 1'b1);
                down_if.WREADY  = mem_random ? 1'($urandom_range(0, 1)) : 1'b1;
                down_if.ARREADY = mem_random ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_wait && !down_if.BVALID && (!mem_random || $urandom_range(0, 1) == 1))
                    down_if.BVALID = 1;
                if (r_wait && !down_if.RVALID && (!mem_random || $urandom_range(0, 1) == 1)) begin
                    down_if.RVALID = 1;
                    down_if.RDATA  = mem_read(r_addr);
                end
                #1;
                if (down_if.AWVALID && down_if.AWREADY) begin
                    cap_addr = down_if.AWADDR; have_aw = 1; aw_hs_count++;
                end
                if (down_if.WVALID && down_if.WREADY) begin
                    cap_data = down_if.WDATA; cap_strb = down_if.WSTRB; have_w = 1;
                end
                if (have_aw && have_w) begin
                    if (exp_q.size() == 0) check("drain_unexpected", 1, 0);
                    else begin
                        check("drain_addr", cap_addr, exp_q[0][63:32]);
                        check("drain_data", cap_data, exp_q[0][31:0]);
                        check("drain_strb", cap_strb, 4'hF);
                    end
                    mem[cap_addr[31:2]] = cap_data;
                    have_aw = 0; have_w = 0; b_wait = 1;
                end
                if (down_if.BVALID && down_if.BREADY) b_hs = 1;
                if (down_if.ARVALID && down_if.ARREADY) begin
                    r_addr = down_if.ARADDR; last_ar_addr = down_if.ARADDR;
                    r_wait = 1; ar_hs_count++;
                end
                if (down_if.RVALID && down_if.RREADY) r_hs = 1;
            end
        end
    end

    // ---------------- upstream driver tasks ----------------
    task automatic up_write(input logic [31:0] addr, input logic [31:0] data, input int bdelay);
        bit done = 0;
        @(negedge clk);
        up_if.AWADDR = addr; up_if.WDATA = data; up_if.WSTRB = 4'hF;
        up_if.AWVALID = 1; up_if.WVALID = 1;
        #2;
        for (int i = 0; i < 300 && !done; i++) begin
            if (up_if.AWREADY && up_if.WREADY) done = 1;
            else begin @(negedge clk); #2; end
        end
        if (!done) begin
            check("write_accept_timeout", 0, 1);
            up_if.AWVALID = 0; up_if.WVALID = 0;
        end else begin
            exp_q.push_back({addr, data});
            shadow[addr[31:2]] = data;
            @(negedge clk);
            up_if.AWVALID = 0; up_if.WVALID = 0;
            check("b_valid", up_if.BVALID, 1);
            check("b_resp", up_if.BRESP, RESP_OK);
            for (int i = 0; i < bdelay; i++) begin
                @(negedge clk);
                check("b_hold", up_if.BVALID, 1);
            end
            up_if.BREADY = 1;
            @(negedge clk);
            up_if.BREADY = 0;
            check("b_cleared", up_if.BVALID, 0);
        end
    endtask

    task automatic up_read(input logic [31:0] addr, input logic [31:0] exp_data, input int rdelay);
        bit done = 0;
        bit hit;
        int lat, ar_before;
        @(negedge clk);
        up_if.ARADDR = addr; up_if.ARVALID = 1;
        #2;
        for (int i = 0; i < 100 && !done; i++) begin
            if (up_if.ARREADY) done = 1;
            else begin @(negedge clk); #2; end
        end
        hit = buffered(addr);
        ar_before = ar_hs_count;
        @(negedge clk);
        up_if.ARVALID = 0;
        if (!done) check("read_accept_timeout", 0, 1);
        else begin
            lat = 1;
            while (!up_if.RVALID && lat < 200) begin @(negedge clk); lat++; end
            check("r_valid", up_if.RVALID, 1);
            check("r_data", up_if.RDATA, exp_data);
            check("r_resp", up_if.RRESP, RESP_OK);
            if (hit) begin
                check("fwd_latency", lat, 1);
                check("fwd_no_down_ar", ar_hs_count - ar_before, 0);
            end else begin
                check("miss_down_ar", ar_hs_count - ar_before, 1);
                check("miss_araddr", last_ar_addr, addr);
            end
            for (int i = 0; i < rdelay; i++) begin
                @(negedge clk);
                check("r_hold_valid", up_if.RVALID, 1);
                check("r_hold_data", up_if.RDATA, exp_data);
            end
            up_if.RREADY = 1;
            @(negedge clk);
            up_if.RREADY = 0;
            check("r_cleared", up_if.RVALID, 0);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((count != 0 || exp_q.size() != 0) && n < 500) begin
            @(negedge clk); n++;
        end
        check(tag, count, 0);
        check({tag, "_q"}, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    int aw_before;
    bit saw_valid;
    logic [31:0] ra, rexp;

    initial begin
        rst = 1;
        up_if.AWADDR = '0; up_if.AWPROT = '0; up_if.AWVALID = 0;
        up_if.WDATA = '0; up_if.WSTRB = 4'hF; up_if.WVALID = 0; up_if.BREADY = 0;
        up_if.ARADDR = '0; up_if.ARPROT = '0; up_if.ARVALID = 0; up_if.RREADY = 0;
        repeat (3) @(negedge clk);
        check("rst_awready", up_if.AWREADY, 0);
        check("rst_arready", up_if.ARREADY, 0);
        check("rst_bvalid", up_if.BVALID, 0);
        check("rst_rvalid", up_if.RVALID, 0);
        check("rst_rdata", up_if.RDATA, 0);
        check("rst_down_valids", {down_if.AWVALID, down_if.WVALID, down_if.ARVALID}, 0);
        check("rst_down_readys", {down_if.BREADY, down_if.RREADY}, 0);
        check("rst_down_addr", {down_if.AWADDR, down_if.ARADDR}, 0);
        check("rst_count", count, 0);
        rst = 0;
        #1;
        check("post_rst_awready", up_if.AWREADY, 1);
        check("post_rst_arready", up_if.ARREADY, 1);

        // single write: drain issue two cycles after accept
        up_write(32'h10, 32'hDEADBEEF, 0);
        check("single_awvalid", down_if.AWVALID, 1);
        check("single_awaddr", down_if.AWADDR, 32'h10);
        check("single_wvalid", down_if.WVALID, 1);
        check("single_wdata", down_if.WDATA, 32'hDEADBEEF);
        wait_drain("single_drain");

        // fill to DEPTH with memory AW stalled; fifth write waits for the first pop
        mem_aw_stall = 1;
        for (int i = 0; i < 4; i++) up_write(32'(4 * i), 32'h100 + 32'(i), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_count", count, 4);
            check("full_awready", up_if.AWREADY, 0);
            check("full_arready", up_if.ARREADY, 1);
        end
        mem_aw_stall = 0;
        up_write(32'h10, 32'h104, 0);
        wait_drain("fill_drain");

        // forwarding from the youngest of two same-word entries
        mem_aw_stall = 1;
        up_write(32'h20, 32'h1, 0);
        up_write(32'h20, 32'h2, 1);
        up_read(32'h20, 32'h2, 0);
        mem_aw_stall = 0;
        wait_drain("fwd_drain");

        // miss while a different-address drain is stalled; RREADY withheld 3 cycles
        mem[32'h40 >> 2] = 32'h55;
        mem_aw_stall = 1;
        up_write(32'h20, 32'h3, 0);
        up_read(32'h40, 32'h55, 3);
        mem_aw_stall = 0;
        wait_drain("miss_drain");

        // reset in the middle of a drain
        mem_aw_stall = 1;
        for (int i = 0; i < 3; i++) up_write(32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 0);
        check("pre_rst_state", drain_state, D_SEND);
        @(negedge clk);
        rst = 1;
        exp_q.delete(); shadow.delete(); mem.delete();
        #1;
        check("midrst_down_valids", {down_if.AWVALID, down_if.WVALID, down_if.ARVALID}, 0);
        check("midrst_up_valids", {up_if.BVALID, up_if.RVALID}, 0);
        check("midrst_count", count, 0);
        check("midrst_state", drain_state, D_IDLE);
        check("midrst_readys", {up_if.AWREADY, up_if.ARREADY}, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check("rel_count", count, 0);
        check("rel_awready", up_if.AWREADY, 1);
        check("rel_arready", up_if.ARREADY, 1);
        aw_before = aw_hs_count;
        mem_aw_stall = 0;
        saw_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (down_if.AWVALID || down_if.WVALID) saw_valid = 1;
        end
        check("rel_no_down_valid", saw_valid, 0);
        check("rel_no_down_aw", aw_hs_count - aw_before, 0);

        // randomized mix over a small word set with random memory timing
        mem_random = 1;
        for (int n = 0; n < 80; n++) begin
            ra = 32'h100 + 32'(4 * $urandom_range(0, 5));
            if ($urandom_range(0, 2) != 0) up_write(ra, $urandom, $urandom_range(0, 2));
            else begin
                rexp = shadow.exists(ra[31:2]) ? shadow[ra[31:2]] : mem_default(ra);
                up_read(ra, rexp, $urandom_range(0, 2));
            end
        end
        mem_random = 0;
        wait_drain("rand_drain");
        for (int i = 0; i < 6; i++) begin
            ra = 32'h100 + 32'(4 * i);
            if (shadow.exists(ra[31:2])) check("rand_mem_final", mem_read(ra), shadow[ra[31:2]]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
